// File: rtl/mux_pkg.sv
// Shared types and constants for the registered channel-select mux.
// Optional feature macro: MUX_ERR_CNT_EN (enables the out-of-range accept counter).
package mux_pkg;

   // Occupancy of the output stage: nothing held, output register only, output + skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } mux_state_t;

   localparam int                   ERR_CNT_W   = 16;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

   // Saturating increment used by the error counter.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready output stage: output register plus one skid register.
// in_ready and all output signals are driven directly from flops.
module mux_skid_buf
   import mux_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   mux_state_t   state_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [W-1:0] out_q;
   logic [W-1:0] skid_q;

   // Occupancy FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_valid) begin
                  out_q       <= in_data;
                  out_valid_q <= 1'b1;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (in_valid && out_ready) begin
                  // Pass-through at full rate: new beat replaces the one leaving.
                  out_q <= in_data;
               end else if (in_valid) begin
                  // Consumer stalled: park the new beat behind the held one.
                  skid_q     <= in_data;
                  in_ready_q <= 1'b0;
                  state_q    <= FULL;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
            FULL: begin
               // in_valid is ignored here; in_ready is already low.
               if (out_ready) begin
                  out_q      <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= BUSY;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q;

endmodule

// File: rtl/mux_pipe.sv
// Registered NUM_INP:1 channel-select mux with valid/ready output and skid buffer.
// Out-of-range selects deliver a zero beat flagged with out_err.
// Optional feature macro: MUX_ERR_CNT_EN -- when defined, err_cnt counts
// out-of-range accepts (saturating); otherwise err_cnt is tied to zero.
module mux_pipe
   import mux_pkg::*;
#(
   parameter int NUM_INP = 32,
   parameter int DATA_W  = 2,
   localparam int SEL_W  = $clog2(NUM_INP)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_INP*DATA_W-1:0] inp_flat,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_err,
   output logic [ERR_CNT_W-1:0]      err_cnt
);

   localparam int              PAY_W     = DATA_W + 1;
   // One extra bit so NUM_INP itself is representable (e.g. 256 with SEL_W=8).
   localparam logic [SEL_W:0] NUM_INP_W = (SEL_W+1)'(NUM_INP);

   logic [DATA_W-1:0] sel_data;
   logic              sel_oob;
   logic              accept;
   logic [PAY_W-1:0]  pay_in;
   logic [PAY_W-1:0]  pay_out;

   // Channel select; an index matching no channel leaves the data at zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_INP; k++) begin
         if (sel == SEL_W'(k)) sel_data = inp_flat[k*DATA_W +: DATA_W];
      end
   end

   // Constant-false when NUM_INP is a power of two.
   assign sel_oob = ({1'b0, sel} >= NUM_INP_W);
   assign accept  = in_valid && in_ready;
   assign pay_in  = {sel_oob, sel_data};

   mux_skid_buf #(
      .W (PAY_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out)
   );

   assign out_err  = pay_out[PAY_W-1];
   assign out_data = pay_out[DATA_W-1:0];

`ifdef MUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Count bad selects when they are accepted, not when they drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (accept && sel_oob) begin
         err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Directed + random bench for mux_pipe: a 32-channel instance for the main
// traffic and a 31-channel instance for out-of-range selects.
module tb_mux_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 32-channel DUT
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
   logic [4:0]  a_sel;
   logic [63:0] a_flat;
   logic [1:0]  a_out_data;
   logic [15:0] a_err_cnt;

   // 31-channel DUT
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
   logic [4:0]  b_sel;
   logic [61:0] b_flat;
   logic [1:0]  b_out_data;
   logic [15:0] b_err_cnt;

   mux_pipe #(.NUM_INP(32), .DATA_W(2)) u_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .sel(a_sel), .inp_flat(a_flat), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_err(a_out_err), .err_cnt(a_err_cnt));

   mux_pipe #(.NUM_INP(31), .DATA_W(2)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel(b_sel), .inp_flat(b_flat), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_err(b_out_err), .err_cnt(b_err_cnt));

   int n_assert = 0;
   int n_fail   = 0;

   logic [2:0] qa[$];
   logic [2:0] qb[$];
   logic       pa_stall = 1'b0, pb_stall = 1'b0;
   logic [3:0] pa_snap = '0, pb_snap = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_a(input logic [4:0] s, input logic [63:0] f);
      return {1'b0, f[s*2 +: 2]};
   endfunction

   function automatic logic [2:0] exp_b(input logic [4:0] s, input logic [61:0] f);
      if (s >= 5'd31) return 3'b100;
      return {1'b0, f[s*2 +: 2]};
   endfunction

   // Called with inputs settled away from the edge: records the handshakes
   // that the coming rising edge will perform, then advances one cycle.
   task automatic cycle();
      logic [2:0] e;
      if (reset) begin
         qa.delete();
         qb.delete();
         pa_stall = 1'b0;
         pb_stall = 1'b0;
      end else begin
         if (a_in_valid && a_in_ready) qa.push_back(exp_a(a_sel, a_flat));
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check("a_spurious_beat", 32'(1), 32'(0));
            else begin
               e = qa.pop_front();
               check("a_beat", 32'({a_out_err, a_out_data}), 32'(e));
            end
         end
         if (pa_stall) check("a_stall_stable", 32'({a_out_valid, a_out_err, a_out_data}), 32'(pa_snap));
         pa_stall = a_out_valid && !a_out_ready;
         pa_snap  = {a_out_valid, a_out_err, a_out_data};

         if (b_in_valid && b_in_ready) qb.push_back(exp_b(b_sel, b_flat));
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check("b_spurious_beat", 32'(1), 32'(0));
            else begin
               e = qb.pop_front();
               check("b_beat", 32'({b_out_err, b_out_data}), 32'(e));
            end
         end
         if (pb_stall) check("b_stall_stable", 32'({b_out_valid, b_out_err, b_out_data}), 32'(pb_snap));
         pb_stall = b_out_valid && !b_out_ready;
         pb_snap  = {b_out_valid, b_out_err, b_out_data};
      end
      @(negedge clk);
   endtask

   initial begin
      int guard;
      logic [15:0] exp_cnt;

      reset = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_sel = '0; a_flat = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_sel = '0; b_flat = '0;
      for (int k = 0; k < 32; k++) a_flat[k*2 +: 2] = 2'(k % 4);
      for (int k = 0; k < 31; k++) b_flat[k*2 +: 2] = 2'(k % 4);
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_in_ready",  32'(a_in_ready), 32'(1));
      check("rst_out_valid", 32'(a_out_valid), 32'(0));
      check("rst_out_data",  32'(a_out_data), 32'(0));
      check("rst_out_err",   32'(a_out_err), 32'(0));
      check("rst_err_cnt",   32'(b_err_cnt), 32'(0));
      reset = 1'b0;

      // Sweep every select with the consumer always ready
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int s = 0; s < 32; s++) begin
         a_sel = 5'(s);
         cycle();
         check("sweep_latency", 32'(a_out_valid), 32'(1));
         check("sweep_data", 32'({a_out_err, a_out_data}), 32'(s % 4));
      end
      a_in_valid = 1'b0;
      cycle();
      check("sweep_drained", 32'(qa.size()), 32'(0));
      check("sweep_idle", 32'(a_out_valid), 32'(0));

      // Backpressure: A (sel 3) then B (sel 5) while stalled
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_sel = 5'd3; cycle();
      a_sel = 5'd5; cycle();
      a_in_valid = 1'b0;
      check("bp_full_not_ready", 32'(a_in_ready), 32'(0));
      check("bp_head_A", 32'(a_out_data), 32'(3));
      a_in_valid = 1'b1; a_sel = 5'd9;   // must be ignored while full
      cycle();
      a_in_valid = 1'b0;
      check("bp_still_full", 32'(a_in_ready), 32'(0));
      a_out_ready = 1'b1;
      cycle();                            // A drains
      check("bp_ready_back", 32'(a_in_ready), 32'(1));
      check("bp_head_B", 32'(a_out_data), 32'(1));
      cycle();                            // B drains
      check("bp_empty", 32'(a_out_valid), 32'(0));
      check("bp_queue_empty", 32'(qa.size()), 32'(0));

      // Out-of-range selects on the 31-channel instance
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_sel = 5'd31;
      repeat (3) cycle();
      b_sel = 5'd30;
      cycle();
      check("oob_last_valid", 32'(b_out_valid), 32'(1));
      check("oob_last_beat", 32'({b_out_err, b_out_data}), 32'(3'b010));
      b_in_valid = 1'b0;
      cycle();
`ifdef MUX_ERR_CNT_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      check("oob_err_cnt", 32'(b_err_cnt), 32'(exp_cnt));
      check("oob_drained", 32'(qb.size()), 32'(0));

      // Random traffic with changing channel data
      for (int i = 0; i < 10000; i++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_out_ready = 1'($urandom_range(0, 1));
         a_sel       = 5'($urandom_range(0, 31));
         a_flat      = {$urandom, $urandom};
         cycle();
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      guard = 0;
      while (qa.size() != 0 && guard < 10) begin
         cycle();
         guard++;
      end
      check("rand_drained", 32'(qa.size()), 32'(0));
      check("rand_idle", 32'(a_out_valid), 32'(0));

      // Reset while FULL, with nonzero error count on the other instance
      b_in_valid = 1'b1; b_sel = 5'd31; cycle();
      b_in_valid = 1'b0;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_sel = 5'd1; cycle();
      a_sel = 5'd2; cycle();
      a_in_valid = 1'b0;
      check("pre_rst_full", 32'(a_in_ready), 32'(0));
      reset = 1'b1;
      a_in_valid = 1'b1; a_out_ready = 1'b1;  // reset must win over both
      cycle();
      reset = 1'b0;
      a_in_valid = 1'b0;
      check("mid_rst_out_valid", 32'(a_out_valid), 32'(0));
      check("mid_rst_in_ready", 32'(a_in_ready), 32'(1));
      check("mid_rst_err_cnt", 32'(b_err_cnt), 32'(0));
      for (int k = 0; k < 32; k++) a_flat[k*2 +: 2] = 2'(k % 4);
      a_in_valid = 1'b1; a_sel = 5'd7;
      cycle();
      a_in_valid = 1'b0;
      check("post_rst_beat", 32'({a_out_valid, a_out_err, a_out_data}), 32'(4'b1011));
      cycle();
      check("post_rst_drained", 32'(qa.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
